// File: rtl/rmgmt_mac_ext_execute.sv
// ---------------------------------------------------------------------------
// rmgmt_mac_ext_execute
// Execute stage of a RISC-MGMT multiply/accumulate extension. Accepts decoded
// custom ops (MUL, MAC, CLRACC, RDACC) and runs an iterative radix-2^MUL_BITS
// shift-add multiplier. The accumulate add goes through the shared core ALU
// (alu_access path).
//
// Parameters:
//   MUL_BITS       multiplier bits retired per cycle (1, 2 or 4)
// Configuration macro:
//   RMGMT_MAC_SATURATE_EN  when defined, the accumulate saturates on signed
//                          overflow; otherwise it wraps modulo 2^32.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, funct_i      op request from decode and its function code
//   kill_i                pipeline flush, aborts the in-flight op
//   rdata_s_0/1_i         rs0 / rs1 operands
//   busy_o                stall request (combinational)
//   reg_w_o, reg_wdata_o  rd write strobe and data
//   exception_o           illegal funct
//   branch_jump_o, br_j_addr_o  unused, tied 0
//   alu_access_o, alu_op_o, alu_data_0/1_o, alu_res_i  shared ALU access
// ---------------------------------------------------------------------------
package rmgmt_mac_pkg;
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLT = 4'd5
   } aluop_t;
endpackage

module rmgmt_mac_ext_execute
   import rmgmt_mac_pkg::*;
#(
   parameter int MUL_BITS = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [2:0]  funct_i,
   input  logic        kill_i,
   input  logic [31:0] rdata_s_0_i,
   input  logic [31:0] rdata_s_1_i,
   output logic        busy_o,
   output logic        reg_w_o,
   output logic [31:0] reg_wdata_o,
   output logic        exception_o,
   output logic        branch_jump_o,
   output logic [31:0] br_j_addr_o,
   output logic        alu_access_o,
   output aluop_t      alu_op_o,
   output logic [31:0] alu_data_0_o,
   output logic [31:0] alu_data_1_o,
   input  logic [31:0] alu_res_i
);

   localparam int ITER = 32 / MUL_BITS;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MAC    = 3'b001;
   localparam logic [2:0] F_CLRACC = 3'b010;
   localparam logic [2:0] F_RDACC  = 3'b011;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [31:0]     acc_q, acc_d;
   logic [31:0]     product_q, product_d;
   logic [31:0]     mcand_q, mcand_d;
   logic [31:0]     mplier_q, mplier_d;
   logic [CW-1:0]   count_q, count_d;
   logic            isMac_q, isMac_d;
   logic [31:0]     partial;
   logic [31:0]     accSum;
   logic            idleStart;
   logic            accept;

   assign idleStart = (state_q == S_IDLE) && start_i && !kill_i;
   assign accept    = idleStart && ((funct_i == F_MUL) || (funct_i == F_MAC));

   // Partial product for this step: the low MUL_BITS multiplier bits each
   // select a shifted copy of the multiplicand. Only the low 32 bits matter,
   // so signed and unsigned operands give the same result.
   always_comb begin
      partial = '0;
      for (int b = 0; b < MUL_BITS; b++) begin
         if (mplier_q[b]) begin
            partial = partial + (mcand_q << b);
         end
      end
   end

   // Value written back to the accumulator in the ACC state. The saturating
   // build detects signed overflow from the sign bits of the operands and the
   // ALU result and clamps to the extreme of the operands' sign.
`ifdef RMGMT_MAC_SATURATE_EN
   logic accOvf;
   assign accOvf = (acc_q[31] == product_q[31]) && (alu_res_i[31] != acc_q[31]);
   assign accSum = accOvf ? (acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : alu_res_i;
`else
   assign accSum = alu_res_i;
`endif

   // Next-state logic. kill is applied last so that it overrides every other
   // transition and leaves the accumulator untouched.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      product_d = product_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      isMac_d   = isMac_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d   = S_MUL;
               mcand_d   = rdata_s_0_i;
               mplier_d  = rdata_s_1_i;
               product_d = '0;
               count_d   = '0;
               isMac_d   = (funct_i == F_MAC);
            end else if (idleStart && (funct_i == F_CLRACC)) begin
               acc_d = '0;
            end
         end
         S_MUL: begin
            product_d = product_q + partial;
            mcand_d   = mcand_q << MUL_BITS;
            mplier_d  = mplier_q >> MUL_BITS;
            count_d   = count_q + CW'(1);
            if (count_q == LAST) begin
               count_d = '0;
               state_d = isMac_q ? S_ACC : S_DONE;
            end
         end
         S_ACC: begin
            acc_d   = accSum;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (kill_i) begin
         state_d = S_IDLE;
         acc_d   = acc_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         product_q <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         isMac_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         isMac_q   <= isMac_d;
      end
   end

   // Interface outputs. These react in the same cycle to start/kill so the
   // core can stall on the request cycle and RDACC completes in one cycle.
   always_comb begin
      busy_o       = accept || (!kill_i && ((state_q == S_MUL) || (state_q == S_ACC)));
      alu_access_o = !kill_i && (state_q == S_ACC);
      alu_data_0_o = alu_access_o ? acc_q : '0;
      alu_data_1_o = alu_access_o ? product_q : '0;
      exception_o  = idleStart && funct_i[2];
      reg_w_o      = 1'b0;
      reg_wdata_o  = '0;
      if (!kill_i && (state_q == S_DONE)) begin
         reg_w_o     = 1'b1;
         reg_wdata_o = isMac_q ? acc_q : product_q;
      end else if (idleStart && (funct_i == F_RDACC)) begin
         reg_w_o     = 1'b1;
         reg_wdata_o = acc_q;
      end
   end

   assign alu_op_o      = ALU_ADD;
   assign branch_jump_o = 1'b0;
   assign br_j_addr_o   = '0;

endmodule

// File: tb/tb_rmgmt_mac_ext_execute.sv
// ---------------------------------------------------------------------------
// tb_rmgmt_mac_ext_execute
// Two DUT lanes: lane 0 with MUL_BITS=1, lane 1 with MUL_BITS=4. A behavioural
// model tracks each lane as "op in flight, age in cycles" and predicts every
// output on every cycle; directed sequences add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_rmgmt_mac_ext_execute;

   logic        clk;
   logic        rst       [2];
   logic        start     [2];
   logic [2:0]  funct     [2];
   logic        kill      [2];
   logic [31:0] rs0       [2];
   logic [31:0] rs1       [2];
   logic        busy      [2];
   logic        regW      [2];
   logic [31:0] regWdata  [2];
   logic        exc       [2];
   logic        brJ       [2];
   logic [31:0] brAddr    [2];
   logic        aluAccess [2];
   rmgmt_mac_pkg::aluop_t aluOp [2];
   logic [31:0] aluD0     [2];
   logic [31:0] aluD1     [2];
   logic [31:0] aluRes    [2];

   int totalCount = 0;
   int badCount   = 0;

   localparam int LANE_ITER [2] = '{32, 8};

   // Stand-in for the core ALU: a plain 32-bit adder.
   assign aluRes[0] = aluD0[0] + aluD1[0];
   assign aluRes[1] = aluD0[1] + aluD1[1];

   rmgmt_mac_ext_execute #(.MUL_BITS(1)) dut0 (
      .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .funct_i(funct[0]),
      .kill_i(kill[0]), .rdata_s_0_i(rs0[0]), .rdata_s_1_i(rs1[0]),
      .busy_o(busy[0]), .reg_w_o(regW[0]), .reg_wdata_o(regWdata[0]),
      .exception_o(exc[0]), .branch_jump_o(brJ[0]), .br_j_addr_o(brAddr[0]),
      .alu_access_o(aluAccess[0]), .alu_op_o(aluOp[0]),
      .alu_data_0_o(aluD0[0]), .alu_data_1_o(aluD1[0]), .alu_res_i(aluRes[0])
   );

   rmgmt_mac_ext_execute #(.MUL_BITS(4)) dut1 (
      .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .funct_i(funct[1]),
      .kill_i(kill[1]), .rdata_s_0_i(rs0[1]), .rdata_s_1_i(rs1[1]),
      .busy_o(busy[1]), .reg_w_o(regW[1]), .reg_wdata_o(regWdata[1]),
      .exception_o(exc[1]), .branch_jump_o(brJ[1]), .br_j_addr_o(brAddr[1]),
      .alu_access_o(aluAccess[1]), .alu_op_o(aluOp[1]),
      .alu_data_0_o(aluD0[1]), .alu_data_1_o(aluD1[1]), .alu_res_i(aluRes[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: bumps the counters and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      totalCount++;
      if (got !== exp) begin
         badCount++;
         $display("[TB] FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   // Drive one lane's inputs for the next cycle.
   task automatic applyStimulus(input int k, input logic s, input logic [2:0] f,
                                input logic kl, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      start[k] = s;
      funct[k] = f;
      kill[k]  = kl;
      rs0[k]   = a;
      rs1[k]   = b;
   endtask

   // Accumulator update as the architecture defines it.
   function automatic logic [31:0] accUpdate(input logic [31:0] a, input logic [31:0] p);
`ifdef RMGMT_MAC_SATURATE_EN
      longint s;
      s = longint'($signed(a)) + longint'($signed(p));
      if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
      return s[31:0];
`else
      return a + p;
`endif
   endfunction

   // Behavioural model: per lane, whether an op is in flight, its kind, its
   // age (1 on the first cycle after the start cycle), the product and acc.
   bit          mValid  [2];
   bit          mActive [2];
   bit          mMac    [2];
   int          mAge    [2];
   logic [31:0] mAcc    [2];
   logic [31:0] mProd   [2];

   // Compare process: predict each lane's outputs, compare, then advance the
   // model across the coming clock edge using the inputs held at this point.
   always @(negedge clk) begin
      logic        eBusy, eRegW, eExc, eAcc;
      logic [31:0] eWdata, eD0, eD1;
      int          L;
      for (int k = 0; k < 2; k++) begin
         L = LANE_ITER[k];
         eBusy = 0; eRegW = 0; eExc = 0; eAcc = 0;
         eWdata = 0; eD0 = 0; eD1 = 0;
         if (!kill[k]) begin
            if (mActive[k]) begin
               if (mAge[k] <= L) eBusy = 1;
               if (mMac[k] && mAge[k] == L + 1) begin
                  eBusy = 1; eAcc = 1; eD0 = mAcc[k]; eD1 = mProd[k];
               end
               if (mAge[k] == (mMac[k] ? L + 2 : L + 1)) begin
                  eRegW = 1; eWdata = mMac[k] ? mAcc[k] : mProd[k];
               end
            end else if (start[k]) begin
               if (funct[k] == 3'd0 || funct[k] == 3'd1) eBusy = 1;
               else if (funct[k] == 3'd3) begin eRegW = 1; eWdata = mAcc[k]; end
               else if (funct[k][2]) eExc = 1;
            end
         end
         if (mValid[k]) begin
            checkOutput($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(eBusy));
            checkOutput($sformatf("reg_w[%0d]", k), 32'(regW[k]), 32'(eRegW));
            checkOutput($sformatf("reg_wdata[%0d]", k), regWdata[k], eWdata);
            checkOutput($sformatf("exception[%0d]", k), 32'(exc[k]), 32'(eExc));
            checkOutput($sformatf("alu_access[%0d]", k), 32'(aluAccess[k]), 32'(eAcc));
            checkOutput($sformatf("alu_data_0[%0d]", k), aluD0[k], eD0);
            checkOutput($sformatf("alu_data_1[%0d]", k), aluD1[k], eD1);
            checkOutput($sformatf("alu_op[%0d]", k), 32'(aluOp[k]), 32'(rmgmt_mac_pkg::ALU_ADD));
            checkOutput($sformatf("branch_jump[%0d]", k), 32'(brJ[k]), 32'd0);
            checkOutput($sformatf("br_j_addr[%0d]", k), brAddr[k], 32'd0);
         end
         if (rst[k]) begin
            mValid[k] = 1; mActive[k] = 0; mAcc[k] = 0; mProd[k] = 0;
         end else if (kill[k]) begin
            mActive[k] = 0;
         end else if (mActive[k]) begin
            if (mMac[k] && mAge[k] == L + 1) mAcc[k] = accUpdate(mAcc[k], mProd[k]);
            if (mAge[k] == (mMac[k] ? L + 2 : L + 1)) mActive[k] = 0;
            else mAge[k] = mAge[k] + 1;
         end else if (start[k]) begin
            if (funct[k] == 3'd0 || funct[k] == 3'd1) begin
               mActive[k] = 1; mMac[k] = (funct[k] == 3'd1); mAge[k] = 1;
               mProd[k] = rs0[k] * rs1[k];
            end else if (funct[k] == 3'd2) begin
               mAcc[k] = 0;
            end
         end
      end
   end

   // Launch a MUL/MAC and wait for its write-back. Returns the written data,
   // the cycle of reg_w and the cycle of alu_access (cycle 0 = start cycle).
   task automatic runOp(input int k, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit hold, output logic [31:0] wdata,
                        output int lat, output int accCyc);
      logic sampledBusy;
      wdata = 0; lat = -1; accCyc = -1;
      applyStimulus(k, 1, f, 0, a, b);
      for (int c = 0; c < 80 && lat < 0; c++) begin
         @(negedge clk);
         if (aluAccess[k]) accCyc = c;
         if (regW[k]) begin lat = c; wdata = regWdata[k]; end
         sampledBusy = busy[k];
         @(posedge clk);
         #1;
         start[k] = hold && sampledBusy;
      end
      if (lat < 0) checkOutput("op_timeout", 32'hFFFF_FFFF, 32'd0);
      start[k] = 0;
   endtask

   task automatic rdAcc(input int k, output logic [31:0] data);
      applyStimulus(k, 1, 3'd3, 0, 0, 0);
      @(negedge clk);
      data = regWdata[k];
      checkOutput("rdacc_reg_w", 32'(regW[k]), 32'd1);
      applyStimulus(k, 0, 3'd0, 0, 0, 0);
   endtask

   task automatic clrAcc(input int k);
      applyStimulus(k, 1, 3'd2, 0, 0, 0);
      applyStimulus(k, 0, 3'd0, 0, 0, 0);
   endtask

   // Start an op, kill it in cycle killAt, and count any reg_w afterwards.
   task automatic killOp(input int k, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int killAt, output int writes);
      writes = 0;
      applyStimulus(k, 1, f, 0, a, b);
      for (int c = 1; c < killAt; c++) applyStimulus(k, 0, 3'd0, 0, 0, 0);
      applyStimulus(k, 0, 3'd0, 1, 0, 0);
      applyStimulus(k, 0, 3'd0, 0, 0, 0);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (regW[k]) writes++;
      end
   endtask

   initial begin
      logic [31:0] d;
      int lat, accCyc, writes;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1; start[k] = 0; funct[k] = 0; kill[k] = 0; rs0[k] = 0; rs1[k] = 0;
         mValid[k] = 0; mActive[k] = 0; mMac[k] = 0; mAge[k] = 0; mAcc[k] = 0; mProd[k] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 0; rst[1] = 0;
      @(negedge clk);
      checkOutput("reset_busy", 32'(busy[0]), 32'd0);
      checkOutput("reset_reg_w", 32'(regW[0]), 32'd0);

      $display("[TB] MUL 7*6, MUL_BITS=1");
      runOp(0, 3'd0, 32'd7, 32'd6, 1, d, lat, accCyc);
      checkOutput("mul_data", d, 32'd42);
      checkOutput("mul_latency", 32'(lat), 32'd33);

      $display("[TB] MAC sequence");
      clrAcc(0);
      runOp(0, 3'd1, 32'd3, 32'd5, 0, d, lat, accCyc);
      checkOutput("mac1_data", d, 32'd15);
      checkOutput("mac1_latency", 32'(lat), 32'd34);
      checkOutput("mac1_acc_cycle", 32'(accCyc), 32'd33);
      rdAcc(0, d);
      checkOutput("rdacc_15", d, 32'd15);
      runOp(0, 3'd1, 32'hFFFF_FFFF, 32'd2, 1, d, lat, accCyc);
      checkOutput("mac2_acc_cycle", 32'(accCyc), 32'd33);
      rdAcc(0, d);
      checkOutput("rdacc_13", d, 32'd13);

      $display("[TB] kill in MUL and ACC");
      killOp(0, 3'd1, 32'd4, 32'd4, 10, writes);
      checkOutput("kill_mul_writes", 32'(writes), 32'd0);
      rdAcc(0, d);
      checkOutput("kill_mul_acc", d, 32'd13);
      killOp(0, 3'd1, 32'd1, 32'd1, 33, writes);
      checkOutput("kill_acc_writes", 32'(writes), 32'd0);
      rdAcc(0, d);
      checkOutput("kill_acc_acc", d, 32'd13);

      $display("[TB] illegal funct and CLRACC");
      applyStimulus(0, 1, 3'b101, 0, 32'd9, 32'd9);
      @(negedge clk);
      checkOutput("illegal_exc", 32'(exc[0]), 32'd1);
      checkOutput("illegal_busy", 32'(busy[0]), 32'd0);
      applyStimulus(0, 0, 3'd0, 0, 0, 0);
      @(negedge clk);
      checkOutput("illegal_exc_drop", 32'(exc[0]), 32'd0);
      clrAcc(0);
      rdAcc(0, d);
      checkOutput("clracc_zero", d, 32'd0);

      $display("[TB] accumulate overflow");
      runOp(0, 3'd1, 32'h7FFF_FFF0, 32'd1, 0, d, lat, accCyc);
      rdAcc(0, d);
      checkOutput("acc_preload", d, 32'h7FFF_FFF0);
      runOp(0, 3'd1, 32'h20, 32'd1, 0, d, lat, accCyc);
`ifdef RMGMT_MAC_SATURATE_EN
      checkOutput("acc_overflow", d, 32'h7FFF_FFFF);
`else
      checkOutput("acc_overflow", d, 32'h8000_0010);
`endif

      $display("[TB] MUL_BITS=4 lane");
      runOp(1, 3'd0, 32'h0000_FFFF, 32'h0000_FFFF, 0, d, lat, accCyc);
      checkOutput("mul4_data", d, 32'hFFFE_0001);
      checkOutput("mul4_latency", 32'(lat), 32'd9);
      runOp(1, 3'd1, 32'd2, 32'd3, 1, d, lat, accCyc);
      checkOutput("mac4_latency", 32'(lat), 32'd10);
      rdAcc(1, d);
      checkOutput("mac4_acc", d, 32'd6);

      $display("[TB] reset mid-MUL");
      applyStimulus(1, 1, 3'd0, 0, 32'd5, 32'd5);
      applyStimulus(1, 0, 3'd0, 0, 0, 0);
      applyStimulus(1, 0, 3'd0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst[1] = 1;
      @(negedge clk);
      checkOutput("rst_cycle_busy", 32'(busy[1]), 32'd1);
      @(posedge clk);
      #1;
      rst[1] = 0;
      @(negedge clk);
      checkOutput("rst_after_busy", 32'(busy[1]), 32'd0);
      rdAcc(1, d);
      checkOutput("rst_acc", d, 32'd0);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
